// File: rtl/vga_pkg.sv
// Shared VGA constants: RGB565 colours, 640x480 screen size and the
// blink controller state encoding.
package vga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;

  typedef enum logic [1:0] {
    BLINK_IDLE   = 2'd0,
    BLINK_SHOWN  = 2'd1,
    BLINK_HIDDEN = 2'd2
  } blink_state_e;

endpackage

// File: rtl/blink_ctrl.sv
// Prompt visibility controller.
// Build option LETTER_BLINK_EN: when defined, the prompt blinks with a
// period of 2*BLINK_FRAMES frames; when undefined, visibility is simply
// the registered show level.
//
// state        | meaning
// -------------+------------------------------------------------
// BLINK_IDLE   | prompt not requested, nothing drawn
// BLINK_SHOWN  | prompt requested, glyphs drawn (visible=1)
// BLINK_HIDDEN | prompt requested, off phase of the blink
module blink_ctrl
  import vga_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_frame_start,
  input  logic i_show,
  output logic o_visible
);

`ifdef LETTER_BLINK_EN

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  blink_state_e r_state;
  blink_state_e w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // state register and frame counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= BLINK_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // next state; dropping show wins over a coincident frame_start
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      BLINK_IDLE: begin
        if (i_show) begin
          w_state_next = BLINK_SHOWN;
          w_cnt_next   = '0;
        end
      end
      BLINK_SHOWN, BLINK_HIDDEN: begin
        if (!i_show) begin
          w_state_next = BLINK_IDLE;
          w_cnt_next   = '0;
        end else if (i_frame_start) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_next   = '0;
            w_state_next = (r_state == BLINK_SHOWN) ? BLINK_HIDDEN : BLINK_SHOWN;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = BLINK_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // visibility is decoded from the registered state only
  always_comb begin
    o_visible = (r_state == BLINK_SHOWN);
  end

`else

  logic r_visible;
  logic w_unused_frame;

  assign w_unused_frame = i_frame_start;

  // no blinking: visibility follows show one cycle later
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_visible <= 1'b0;
    else         r_visible <= i_show;
  end

  assign o_visible = r_visible;

`endif

endmodule

// File: rtl/letter_overlay.sv
// Two-stage text-box overlay on an RGB565 pixel stream.
// Stage 1 decodes the box and addresses the external glyph ROM; stage 2
// composites the ROM bit over the delayed pixel. Blinking is enabled by
// defining LETTER_BLINK_EN (see blink_ctrl).
module letter_overlay
  import vga_pkg::*;
#(
  parameter int          ORIGIN_X     = 220,
  parameter int          ORIGIN_Y     = 232,
  parameter int          BOX_W        = 208,
  parameter int          BOX_H        = 16,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] FG_COLOR     = COLOR_WHITE
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic [15:0] pix_data_in,
  input  logic        frame_start,
  input  logic        show,
  output logic [7:0]  letter_x,
  output logic [7:0]  letter_y,
  input  logic        letter_bit,
  output logic [15:0] pix_data_out,
  output logic        pix_valid_out
);

  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + BOX_W - 1);
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + BOX_H - 1);

  logic        w_in_box;
  logic [7:0]  w_dx;
  logic [7:0]  w_dy;
  logic        w_visible;

  logic        r_in_box_d1;
  logic [7:0]  r_letter_x;
  logic [7:0]  r_letter_y;
  logic        r_pix_valid_d1;
  logic [15:0] r_pix_data_d1;
  logic        r_pix_valid_out;
  logic [15:0] r_pix_data_out;

  assign w_in_box = pix_valid
                  && (pix_x >= X_LO) && (pix_x <= X_HI)
                  && (pix_y >= Y_LO) && (pix_y <= Y_HI);
  assign w_dx = 8'(pix_x - X_LO);
  assign w_dy = 8'(pix_y - Y_LO);

  blink_ctrl #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_ctrl (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .i_frame_start (frame_start),
    .i_show        (show),
    .o_visible     (w_visible)
  );

  // stage 1: box decode, ROM address, pixel delay
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_in_box_d1    <= 1'b0;
      r_letter_x     <= '0;
      r_letter_y     <= '0;
      r_pix_valid_d1 <= 1'b0;
      r_pix_data_d1  <= '0;
    end else begin
      r_in_box_d1    <= w_in_box;
      r_letter_x     <= w_in_box ? w_dx : 8'd0;
      r_letter_y     <= w_in_box ? w_dy : 8'd0;
      r_pix_valid_d1 <= pix_valid;
      r_pix_data_d1  <= pix_data_in;
    end
  end

  // stage 2: composite lit glyph pixels; blank data outside the active area
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pix_valid_out <= 1'b0;
      r_pix_data_out  <= '0;
    end else begin
      r_pix_valid_out <= r_pix_valid_d1;
      if (!r_pix_valid_d1)
        r_pix_data_out <= COLOR_BLACK;
      else if (r_in_box_d1 && letter_bit && w_visible)
        r_pix_data_out <= FG_COLOR;
      else
        r_pix_data_out <= r_pix_data_d1;
    end
  end

  assign letter_x      = r_letter_x;
  assign letter_y      = r_letter_y;
  assign pix_valid_out = r_pix_valid_out;
  assign pix_data_out  = r_pix_data_out;

endmodule

// File: tb/tb_letter_overlay.sv
// Bench for letter_overlay: table of single-pixel vectors, then sequences
// for glyph addressing, blinking, show drop and mid-stream reset.
module tb_letter_overlay;

  localparam int OX = 220;
  localparam int OY = 232;
  localparam int BW = 208;
  localparam int BH = 16;
  localparam int BF = 30;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [15:0] pix_data_in;
  logic        frame_start;
  logic        show;
  logic [7:0]  letter_x;
  logic [7:0]  letter_y;
  logic        letter_bit;
  logic [15:0] pix_data_out;
  logic        pix_valid_out;
  logic        rom_all;

  always #5 sys_clk = ~sys_clk;

  // glyph ROM stand-in: all ones, or a checkerboard on the cell offsets
  assign letter_bit = rom_all ? 1'b1 : (letter_x[0] ^ letter_y[0]);

  letter_overlay dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_valid     (pix_valid),
    .pix_data_in   (pix_data_in),
    .frame_start   (frame_start),
    .show          (show),
    .letter_x      (letter_x),
    .letter_y      (letter_y),
    .letter_bit    (letter_bit),
    .pix_data_out  (pix_data_out),
    .pix_valid_out (pix_valid_out)
  );

  typedef struct {
    int          x;
    int          y;
    bit          v;
    logic [15:0] d;
    bit          sh;
    int          lx;
    int          ly;
    logic [15:0] out;
    bit          vout;
  } vec_t;

  typedef struct {
    bit          vout;
    logic [15:0] out;
    string       name;
  } exp_t;

  exp_t q[$];
  vec_t tbl[11];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of visibility after each clock edge
  int m_state;
  int m_cnt;
  bit m_vis;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit fs, input bit sh);
`ifdef LETTER_BLINK_EN
    if (m_state == 0) begin
      if (sh) begin m_state = 1; m_cnt = 0; end
    end else begin
      if (!sh) begin
        m_state = 0; m_cnt = 0;
      end else if (fs) begin
        if (m_cnt == BF - 1) begin
          m_cnt = 0;
          m_state = (m_state == 1) ? 2 : 1;
        end else begin
          m_cnt++;
        end
      end
    end
    m_vis = (m_state == 1);
`else
    m_cnt = fs ? m_cnt + 1 : m_cnt;
    m_vis = sh;
`endif
  endtask

  // one pixel per clock; expectations either hand-given or from the model
  task automatic cycle(input int x, input int y, input bit v, input logic [15:0] d,
                       input bit fs, input bit sh, input bit use_model,
                       input int hlx, input int hly, input logic [15:0] hout,
                       input bit hvout, input string name);
    bit inb;
    int lx, ly;
    exp_t e;
    exp_t o;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    pix_valid   = v;
    pix_data_in = d;
    frame_start = fs;
    show        = sh;
    model_step(fs, sh);
    if (use_model) begin
      inb = v && x >= OX && x <= OX + BW - 1 && y >= OY && y <= OY + BH - 1;
      lx  = inb ? x - OX : 0;
      ly  = inb ? y - OY : 0;
      e.vout = v;
      if (!v)
        e.out = 16'h0000;
      else if (inb && (rom_all || (((lx ^ ly) & 1) == 1)) && m_vis)
        e.out = 16'hFFFF;
      else
        e.out = d;
    end else begin
      lx = hlx;
      ly = hly;
      e.vout = hvout;
      e.out  = hout;
    end
    e.name = name;
    q.push_back(e);
    @(posedge sys_clk);
    #1;
    chk({name, "/letter_x"}, int'(letter_x), lx);
    chk({name, "/letter_y"}, int'(letter_y), ly);
    if (q.size() >= 2) begin
      o = q.pop_front();
      chk({o.name, "/valid_out"}, int'(pix_valid_out), int'(o.vout));
      chk({o.name, "/data_out"}, int'(pix_data_out), int'(o.out));
    end
    frame_start = 1'b0;
  endtask

  task automatic mcycle(input int x, input int y, input bit v, input logic [15:0] d,
                        input bit fs, input bit sh, input string name);
    cycle(x, y, v, d, fs, sh, 1'b1, 0, 0, 16'h0, 1'b0, name);
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    sys_rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      chk("rst/valid_out", int'(pix_valid_out), 0);
      chk("rst/data_out", int'(pix_data_out), 0);
      chk("rst/letter_x", int'(letter_x), 0);
      chk("rst/letter_y", int'(letter_y), 0);
    end
    sys_rst = 1'b0;
    q.delete();
    z.vout = 1'b0;
    z.out  = 16'h0000;
    z.name = "post_rst";
    q.push_back(z);
    m_state = 0;
    m_cnt   = 0;
    m_vis   = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    pix_data_in = '0; frame_start = 1'b0; show = 1'b0; rom_all = 1'b1;
    m_state = 0; m_cnt = 0; m_vis = 1'b0;

    //          x    y   v  data      sh  lx   ly  out       vout
    tbl[0]  = '{220, 232, 1, 16'h1234, 1, 0,   0,  16'hFFFF, 1};
    tbl[1]  = '{427, 247, 1, 16'h5555, 1, 207, 15, 16'hFFFF, 1};
    tbl[2]  = '{428, 232, 1, 16'hABCD, 1, 0,   0,  16'hABCD, 1};
    tbl[3]  = '{220, 248, 1, 16'h0F0F, 1, 0,   0,  16'h0F0F, 1};
    tbl[4]  = '{219, 240, 1, 16'h1111, 1, 0,   0,  16'h1111, 1};
    tbl[5]  = '{220, 231, 1, 16'h2222, 1, 0,   0,  16'h2222, 1};
    tbl[6]  = '{300, 240, 0, 16'h3333, 1, 0,   0,  16'h0000, 0};
    tbl[7]  = '{300, 240, 1, 16'h4444, 0, 80,  8,  16'h4444, 1};
    tbl[8]  = '{300, 240, 1, 16'h4444, 1, 80,  8,  16'hFFFF, 1};
    tbl[9]  = '{0,   0,   1, 16'h00FF, 1, 0,   0,  16'h00FF, 1};
    tbl[10] = '{639, 479, 1, 16'hF800, 1, 0,   0,  16'hF800, 1};

    do_reset(3);

    for (int i = 0; i < 11; i++)
      cycle(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].d, 1'b0, tbl[i].sh, 1'b0,
            tbl[i].lx, tbl[i].ly, tbl[i].out, tbl[i].vout, $sformatf("tbl%0d", i));
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "flush_tbl");

    // checkerboard glyph walk across the box corner
    rom_all = 1'b0;
    for (int i = 0; i < 8; i++)
      mcycle(OX + i, OY + (i / 2), 1'b1, 16'(16'h0100 + i), 1'b0, 1'b1, $sformatf("chk%0d", i));
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "flush_chk");
    rom_all = 1'b1;

    // blink: show from idle, then BF frame pulses hide (blink build only)
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b0, "blk_idle");
    mcycle(OX, OY, 1'b1, 16'h0BAD, 1'b0, 1'b1, "blk_on");
    for (int f = 0; f < BF; f++)
      mcycle(OX + 5, OY + 3, 1'b1, 16'(f), 1'b1, 1'b1, $sformatf("blk_fs%0d", f));
`ifdef LETTER_BLINK_EN
    cycle(OX + 1, OY + 1, 1'b1, 16'h1357, 1'b0, 1'b1, 1'b0, 1, 1, 16'h1357, 1'b1, "blk_hidden");
`else
    cycle(OX + 1, OY + 1, 1'b1, 16'h1357, 1'b0, 1'b1, 1'b0, 1, 1, 16'hFFFF, 1'b1, "blk_hidden");
`endif
    for (int f = 0; f < BF; f++)
      mcycle(OX + 6, OY + 4, 1'b1, 16'(f), 1'b1, 1'b1, $sformatf("blk2_fs%0d", f));
    cycle(OX + 2, OY + 2, 1'b1, 16'h2244, 1'b0, 1'b1, 1'b0, 2, 2, 16'hFFFF, 1'b1, "blk_shown");
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "flush_blk");

    // show drops on the same cycle as the BF-th frame pulse
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b0, "drop_idle");
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "drop_on");
    for (int f = 0; f < BF - 1; f++)
      mcycle(OX + 7, OY + 7, 1'b1, 16'(f), 1'b1, 1'b1, $sformatf("drop_fs%0d", f));
    mcycle(OX + 7, OY + 7, 1'b1, 16'h7777, 1'b1, 1'b0, "drop_last");
    cycle(OX + 3, OY + 3, 1'b1, 16'h2468, 1'b0, 1'b0, 1'b0, 3, 3, 16'h2468, 1'b1, "drop_gone");
    mcycle(OX + 3, OY + 3, 1'b1, 16'h0C0C, 1'b0, 1'b1, "drop_reshow");
    for (int f = 0; f < BF - 1; f++)
      mcycle(OX + 8, OY + 8, 1'b1, 16'(f), 1'b1, 1'b1, $sformatf("re_fs%0d", f));
    cycle(OX + 4, OY + 4, 1'b1, 16'h0AAA, 1'b0, 1'b1, 1'b0, 4, 4, 16'hFFFF, 1'b1, "re_cnt0");
    mcycle(OX + 8, OY + 8, 1'b1, 16'h0, 1'b1, 1'b1, "re_fs_last");
`ifdef LETTER_BLINK_EN
    cycle(OX + 4, OY + 4, 1'b1, 16'h0BBB, 1'b0, 1'b1, 1'b0, 4, 4, 16'h0BBB, 1'b1, "re_hidden");
`else
    cycle(OX + 4, OY + 4, 1'b1, 16'h0BBB, 1'b0, 1'b1, 1'b0, 4, 4, 16'hFFFF, 1'b1, "re_hidden");
`endif
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "flush_re");

    // reset in the middle of a lit box run drops in-flight pixels
    mcycle(OX + 9, OY + 9, 1'b1, 16'h5A5A, 1'b0, 1'b1, "mid_a");
    mcycle(OX + 10, OY + 9, 1'b1, 16'h5A5B, 1'b0, 1'b1, "mid_b");
    do_reset(2);
    cycle(OX + 11, OY + 9, 1'b1, 16'h5A5C, 1'b0, 1'b1, 1'b0, 11, 9, 16'hFFFF, 1'b1, "rel_a");
    mcycle(OX + 12, OY + 9, 1'b1, 16'h5A5D, 1'b0, 1'b1, "rel_b");
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "flush_end");
    mcycle(0, 0, 1'b0, 16'h0, 1'b0, 1'b1, "flush_end2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
